muldiv_ctrl: RTL and testbench

Sequencing controller for the execute stage's multi-cycle arithmetic units: the Booth multiplier and the iterative divider. Accepts one MULT/DIV instruction at a time from the pipeline. Launches the selected unit with a single-cycle start pulse and stalls the pipeline until the unit reports ready or a watchdog expires. Then presents the result, exception flag and destination tag to writeback for exactly one cycle.

---
 rtl/muldiv_ctrl_pkg.sv | 34 +++
 rtl/muldiv_ctrl_watchdog.sv | 52 +++++
 rtl/muldiv_ctrl.sv | 146 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the multi-cycle arithmetic sequencing controller.
//   state_t      : controller FSM states (IDLE=0, LAUNCH=1, WAIT=2, DONE=3)
//   op_t         : execute-stage op codes for the MULT/DIV path
//   DEF_TIMEOUT  : default watchdog limit in WAIT cycles
//   DEF_BLANK    : default number of WAIT cycles during which unit ready is ignored
//   is_unit_op() : true for op codes that launch a multi-cycle unit
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_MULT = 2'b01,
      OP_DIV  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   localparam int DEF_TIMEOUT = 40;
   localparam int DEF_BLANK   = 2;

   // Reserved and none codes never start a unit; only MULT and DIV do.
   function automatic logic is_unit_op(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_watchdog
// Blanking and timeout counters for one in-flight multi-cycle operation.
// Both counters are loaded by clr and count down while en is high.
//   clock      in  : rising-edge clock
//   reset      in  : synchronous active-high reset
//   clr        in  : load both counters (asserted in LAUNCH)
//   en         in  : count one WAIT cycle
//   expired    out : this WAIT cycle is the TIMEOUT-th one
//   blank_done out : blanking window is over, unit ready may be trusted
// -----------------------------------------------------------------------------
module muldiv_ctrl_watchdog #(
   parameter int TIMEOUT = 40,
   parameter int BLANK   = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired,
   output logic blank_done
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

   logic [TW-1:0] wd_cnt;
   logic [BW-1:0] blank_cnt;

   // The watchdog is loaded with TIMEOUT-1 so it reads zero during the last
   // permitted WAIT cycle; both counters stick at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt    <= '0;
         blank_cnt <= '0;
      end else if (clr) begin
         wd_cnt    <= TW'(TIMEOUT - 1);
         blank_cnt <= BW'(BLANK);
      end else if (en) begin
         if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - TW'(1);
         end
         if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - BW'(1);
         end
      end
   end

   assign expired    = en && (wd_cnt == '0);
   assign blank_done = (blank_cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences one MULT or DIV at a time through the Booth multiplier or the
// iterative divider, stalls the pipeline while the unit works, and hands the
// result to writeback for exactly one cycle.
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   ex_valid, ex_op, ex_rd       : instruction from the execute stage
//   ex_a, ex_b                   : operands
//   flush                        : kill the in-flight op
//   start_mult, start_div        : one-cycle launch pulses to the units
//   unit_a, unit_b               : registered operands shared by both units
//   mult_/div_result,_ready,_exc : unit responses
//   stall                        : hold the pipeline (combinational)
//   wb_valid, wb_rd, wb_data, wb_exc : writeback handoff
//   busy                         : controller not idle (combinational)
// -----------------------------------------------------------------------------
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int BLANK   = DEF_BLANK
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [1:0]       ex_op,
   input  logic [4:0]       ex_rd,
   input  logic [WIDTH-1:0] ex_a,
   input  logic [WIDTH-1:0] ex_b,
   input  logic             flush,
   output logic             start_mult,
   output logic             start_div,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   input  logic [WIDTH-1:0] mult_result,
   input  logic [WIDTH-1:0] div_result,
   input  logic             mult_ready,
   input  logic             div_ready,
   input  logic             mult_exc,
   input  logic             div_exc,
   output logic             stall,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic             wb_exc,
   output logic             busy
);

   state_t           state;
   op_t              op_q;
   logic [4:0]       rd_q;
   logic             wb_valid_q;
   logic             accept;
   logic             sel_ready;
   logic             sel_exc;
   logic [WIDTH-1:0] sel_result;
   logic             expired;
   logic             blank_done;

   muldiv_ctrl_watchdog #(
      .TIMEOUT (TIMEOUT),
      .BLANK   (BLANK)
   ) u_watchdog (
      .clock      (clock),
      .reset      (reset),
      .clr        (state == ST_LAUNCH),
      .en         (state == ST_WAIT),
      .expired    (expired),
      .blank_done (blank_done)
   );

   // Reset outranks accept, so a reset cycle never raises stall or launches.
   assign accept = (state == ST_IDLE) && ex_valid && is_unit_op(ex_op) && !flush && !reset;

   // Only the unit that was launched is listened to.
   assign sel_ready  = (op_q == OP_DIV) ? div_ready  : mult_ready;
   assign sel_exc    = (op_q == OP_DIV) ? div_exc    : mult_exc;
   assign sel_result = (op_q == OP_DIV) ? div_result : mult_result;

   assign stall = accept || (state == ST_LAUNCH) || (state == ST_WAIT);
   assign busy  = (state != ST_IDLE);

   // A flush arriving in the DONE cycle itself must still cancel the
   // writeback, which a purely registered flag cannot do.
   assign wb_valid = wb_valid_q && !flush;

   // Controller FSM with its registered outputs. When a real ready and the
   // watchdog expiry coincide, the real result is kept.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         op_q       <= OP_NONE;
         rd_q       <= '0;
         start_mult <= 1'b0;
         start_div  <= 1'b0;
         unit_a     <= '0;
         unit_b     <= '0;
         wb_valid_q <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_exc     <= 1'b0;
      end else begin
         start_mult <= 1'b0;
         start_div  <= 1'b0;
         wb_valid_q <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q       <= op_t'(ex_op);
                  rd_q       <= ex_rd;
                  unit_a     <= ex_a;
                  unit_b     <= ex_b;
                  start_mult <= (ex_op == OP_MULT);
                  start_div  <= (ex_op == OP_DIV);
                  state      <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               state <= flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else if (blank_done && sel_ready) begin
                  wb_data    <= sel_result;
                  wb_exc     <= sel_exc;
                  wb_rd      <= rd_q;
                  wb_valid_q <= 1'b1;
                  state      <= ST_DONE;
               end else if (expired) begin
                  wb_data    <= '0;
                  wb_exc     <= 1'b1;
                  wb_rd      <= rd_q;
                  wb_valid_q <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl. Each operation is described by its
// operands, the cycle on which the selected unit answers, stale ready cycles
// and an optional flush/reset; the expected writeback cycle and contents are
// worked out from the timing rules before the operation is played.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 40;
   localparam int BLANK   = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic             ex_valid;
   logic [1:0]       ex_op;
   logic [4:0]       ex_rd;
   logic [WIDTH-1:0] ex_a;
   logic [WIDTH-1:0] ex_b;
   logic             flush;
   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] unit_a;
   logic [WIDTH-1:0] unit_b;
   logic [WIDTH-1:0] mult_result;
   logic [WIDTH-1:0] div_result;
   logic             mult_ready;
   logic             div_ready;
   logic             mult_exc;
   logic             div_exc;
   logic             stall;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             wb_exc;
   logic             busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   muldiv_ctrl #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT),
      .BLANK   (BLANK)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .ex_valid    (ex_valid),
      .ex_op       (ex_op),
      .ex_rd       (ex_rd),
      .ex_a        (ex_a),
      .ex_b        (ex_b),
      .flush       (flush),
      .start_mult  (start_mult),
      .start_div   (start_div),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .mult_result (mult_result),
      .div_result  (div_result),
      .mult_ready  (mult_ready),
      .div_ready   (div_ready),
      .mult_exc    (mult_exc),
      .div_exc     (div_exc),
      .stall       (stall),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_exc      (wb_exc),
      .busy        (busy)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idleInputs();
      ex_valid    = 1'b0;
      ex_op       = 2'b00;
      ex_rd       = '0;
      ex_a        = '0;
      ex_b        = '0;
      flush       = 1'b0;
      mult_ready  = 1'b0;
      div_ready   = 1'b0;
      mult_exc    = 1'b0;
      div_exc     = 1'b0;
      mult_result = '0;
      div_result  = '0;
   endtask

   // Plays one operation. Cycle 0 is the accept cycle, start goes out in
   // cycle 1. lat: selected unit ready arrives lat cycles after the start
   // pulse (-1 = never). stale: selected ready also high in cycles 1..stale.
   // killAt: cycle of a flush (or reset when killReset) (-1 = none).
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input int lat, input logic exc, input int stale,
                                input int killAt, input bit killReset, input bit flushInDone);
      bit          rdy [0:63];
      int          done;
      bit          timedOut;
      bit          killed;
      bit          alive;
      bit          isMult;
      int          lastCycle;
      logic [31:0] multRes;
      logic [31:0] divRes;
      logic [31:0] expData;
      logic        expExc;
      logic        otherReady;

      isMult  = (op == 2'b01);
      multRes = a * b;
      divRes  = (b != 0) ? (a / b) : 32'hFFFF_FFFF;

      for (int i = 0; i < 64; i++) rdy[i] = 1'b0;
      for (int i = 1; i <= stale; i++) rdy[i] = 1'b1;
      if (lat >= 0 && 1 + lat < 64) rdy[1 + lat] = 1'b1;

      // WAIT occupies cycles 2..1+TIMEOUT; its first BLANK cycles ignore ready.
      done     = 2 + TIMEOUT;
      timedOut = 1'b1;
      for (int r = 2 + BLANK; r <= 1 + TIMEOUT; r++) begin
         if (rdy[r]) begin
            done     = r + 1;
            timedOut = 1'b0;
            break;
         end
      end
      expData = timedOut ? 32'h0 : (isMult ? multRes : divRes);
      expExc  = timedOut ? 1'b1 : exc;

      killed    = (killAt >= 1) && (killAt < done);
      lastCycle = killed ? (((killAt + 1 > done) ? killAt + 1 : done) + 1) : done;

      for (int n = 0; n <= lastCycle; n++) begin
         alive = !killed || (n <= killAt);
         reset = killed && killReset && (n == killAt);
         flush = (killed && !killReset && (n == killAt)) || (flushInDone && !killed && (n == done));
         if (n == 0) begin
            ex_valid = 1'b1;
            ex_op    = op;
            ex_rd    = rd;
            ex_a     = a;
            ex_b     = b;
         end else if (alive && n <= done) begin
            ex_valid = 1'b1;
            ex_op    = 2'($urandom_range(1, 2));
            ex_rd    = 5'($urandom);
            ex_a     = $urandom;
            ex_b     = $urandom;
         end else begin
            ex_valid = 1'b0;
            ex_op    = 2'b00;
         end
         otherReady  = 1'($urandom_range(0, 1));
         mult_ready  = isMult ? rdy[n] : otherReady;
         div_ready   = isMult ? otherReady : rdy[n];
         mult_exc    = isMult ? exc : ~exc;
         div_exc     = isMult ? ~exc : exc;
         mult_result = multRes;
         div_result  = divRes;
         #1;
         checkOutput($sformatf("stall@%0d", n), stall, (alive && n < done));
         checkOutput($sformatf("busy@%0d", n), busy, (alive && n >= 1 && n <= done));
         checkOutput($sformatf("start_mult@%0d", n), start_mult, (alive && n == 1 && isMult));
         checkOutput($sformatf("start_div@%0d", n), start_div, (alive && n == 1 && !isMult));
         checkOutput($sformatf("wb_valid@%0d", n), wb_valid, (!killed && n == done && !flushInDone));
         if (alive && n >= 1 && n <= done) begin
            checkOutput($sformatf("unit_a@%0d", n), unit_a, a);
            checkOutput($sformatf("unit_b@%0d", n), unit_b, b);
         end
         if (!killed && n == done) begin
            checkOutput("wb_data", wb_data, expData);
            checkOutput("wb_exc", wb_exc, expExc);
            checkOutput("wb_rd", wb_rd, rd);
         end
         if (killed && killReset && n == killAt + 1) begin
            checkOutput("rst_wb_data", wb_data, 0);
            checkOutput("rst_wb_rd", wb_rd, 0);
            checkOutput("rst_wb_exc", wb_exc, 0);
            checkOutput("rst_unit_a", unit_a, 0);
            checkOutput("rst_unit_b", unit_b, 0);
         end
         tick();
      end
      reset = 1'b0;
      idleInputs();
   endtask

   // Presents an instruction that must not be accepted.
   task automatic probeNoAccept(input logic valid, input logic [1:0] op, input logic fl);
      ex_valid = valid;
      ex_op    = op;
      ex_a     = $urandom;
      ex_b     = $urandom;
      flush    = fl;
      #1;
      checkOutput("noacc_stall", stall, 0);
      tick();
      checkOutput("noacc_busy", busy, 0);
      checkOutput("noacc_start_mult", start_mult, 0);
      checkOutput("noacc_start_div", start_div, 0);
      idleInputs();
   endtask

   initial begin
      idleInputs();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_wb_valid", wb_valid, 0);
      checkOutput("rst_wb_exc", wb_exc, 0);
      checkOutput("rst_wb_data", wb_data, 0);
      checkOutput("rst_wb_rd", wb_rd, 0);
      checkOutput("rst_unit_a", unit_a, 0);
      checkOutput("rst_unit_b", unit_b, 0);
      checkOutput("rst_start_mult", start_mult, 0);
      checkOutput("rst_start_div", start_div, 0);

      // Reset must win over a valid instruction.
      ex_valid = 1'b1;
      ex_op    = 2'b01;
      ex_a     = 32'd5;
      #1;
      checkOutput("rst_accept_stall", stall, 0);
      tick();
      checkOutput("rst_accept_busy", busy, 0);
      reset = 1'b0;
      idleInputs();
      tick();

      $display("[TB] directed operations");
      applyStimulus(2'b01, 32'd3, 32'd7, 5'd9, 33, 1'b0, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b10, 32'd100, 32'd7, 5'd17, 33, 1'b0, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'h4000_0000, 32'd4, 5'd3, 33, 1'b1, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd11, 32'd13, 5'd30, 33, 1'b0, 3, -1, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd5, 32'd6, 5'd7, 33, 1'b0, 0, 11, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd2, 32'd2, 5'd8, 33, 1'b0, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b10, 32'd9, 32'd3, 5'd1, -1, 1'b0, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b10, 32'd50, 32'd5, 5'd2, 20, 1'b0, 0, 15, 1'b1, 1'b0);
      applyStimulus(2'b01, 32'd4, 32'd4, 5'd4, 10, 1'b0, 0, -1, 1'b0, 1'b1);
      applyStimulus(2'b10, 32'd81, 32'd9, 5'd5, 3, 1'b0, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd8, 32'd8, 5'd6, 2, 1'b0, 0, -1, 1'b0, 1'b0);
      applyStimulus(2'b01, 32'd1, 32'd1, 5'd11, 20, 1'b0, 0, 1, 1'b0, 1'b0);

      probeNoAccept(1'b1, 2'b11, 1'b0);
      probeNoAccept(1'b1, 2'b00, 1'b0);
      probeNoAccept(1'b1, 2'b01, 1'b1);
      probeNoAccept(1'b0, 2'b10, 1'b0);

      $display("[TB] random operations");
      for (int t = 0; t < 25; t++) begin
         logic [1:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         int          rlat;
         int          rkill;
         bit          rkillRst;
         bit          rflushDone;
         rop        = 2'($urandom_range(1, 2));
         ra         = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         rb         = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
         rlat       = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 38));
         rkill      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : -1;
         rkillRst   = 1'($urandom_range(0, 1));
         rflushDone = ($urandom_range(0, 7) == 0);
         applyStimulus(rop, ra, rb, 5'($urandom), rlat, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 4)), rkill, rkillRst, rflushDone);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
